// File: rtl/iob_timer_alarm_if.sv
// Control/compare bundle between the register file, iob_timer_alarm and timer_core.
// Optional reload/miss signals exist only when TIMER_ALARM_PERIODIC_EN is defined.
interface iob_timer_alarm_if #(
    parameter int DATA_W = 32
);
    localparam int CNT_W = 2 * DATA_W;

    logic [CNT_W-1:0] timer_value;
    logic             timer_enable;
    logic             timer_sample;
    logic             en_req;
    logic             arm;
    logic             disarm;
    logic [CNT_W-1:0] delay;
    logic             irq;
    logic             irq_ack;
    logic [2:0]       state;
`ifdef TIMER_ALARM_PERIODIC_EN
    logic [CNT_W-1:0] period;
    logic [7:0]       miss_cnt;

    modport master (
        output timer_value, en_req, arm, disarm, delay, irq_ack, period,
        input  timer_enable, timer_sample, irq, state, miss_cnt
    );
    modport slave (
        input  timer_value, en_req, arm, disarm, delay, irq_ack, period,
        output timer_enable, timer_sample, irq, state, miss_cnt
    );
`else
    modport master (
        output timer_value, en_req, arm, disarm, delay, irq_ack,
        input  timer_enable, timer_sample, irq, state
    );
    modport slave (
        input  timer_value, en_req, arm, disarm, delay, irq_ack,
        output timer_enable, timer_sample, irq, state
    );
`endif
endinterface

// File: rtl/iob_timer_alarm.sv
// Alarm/compare sequencer for the 64-bit timer_core: relative-delay alarm with level irq.
// Define TIMER_ALARM_PERIODIC_EN for periodic reload and the saturating miss counter.
module iob_timer_alarm #(
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst,
    iob_timer_alarm_if.slave bus
);
    localparam int CNT_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_LOAD   = 3'd2,
        S_ARMED  = 3'd3,
        S_FIRED  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             irq_q, irq_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] diff;
    logic             expired;
`ifdef TIMER_ALARM_PERIODIC_EN
    logic [7:0]       miss_cnt_q, miss_cnt_d;
`endif

    // Signed difference keeps the compare correct across counter wrap and rollback.
    assign diff    = target_q - bus.timer_value;
    assign expired = diff[CNT_W-1] | (diff == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            irq_q    <= 1'b0;
            target_q <= '0;
            delay_q  <= '0;
`ifdef TIMER_ALARM_PERIODIC_EN
            miss_cnt_q <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_d;
            target_q <= target_d;
            delay_q  <= delay_d;
`ifdef TIMER_ALARM_PERIODIC_EN
            miss_cnt_q <= miss_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        target_d = target_q;
        delay_d  = delay_q;
`ifdef TIMER_ALARM_PERIODIC_EN
        miss_cnt_d = miss_cnt_q;
`endif
        if (bus.disarm) begin
            state_d = S_IDLE;
            irq_d   = 1'b0;
`ifdef TIMER_ALARM_PERIODIC_EN
            miss_cnt_d = 8'd0;
`endif
        end else if (bus.arm) begin
            state_d = S_SAMPLE;
            irq_d   = 1'b0;
            delay_d = bus.delay;
`ifdef TIMER_ALARM_PERIODIC_EN
            miss_cnt_d = 8'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_IDLE;
                S_SAMPLE: state_d = S_LOAD;
                S_LOAD: begin
                    target_d = bus.timer_value + delay_q;
                    state_d  = S_ARMED;
                end
                S_ARMED: begin
`ifdef TIMER_ALARM_PERIODIC_EN
                    if (bus.irq_ack) irq_d = 1'b0;
`endif
                    // A fresh expiry overrides a same-cycle acknowledge.
                    if (expired) begin
                        irq_d = 1'b1;
`ifdef TIMER_ALARM_PERIODIC_EN
                        if (irq_q && (miss_cnt_q != 8'hFF)) miss_cnt_d = miss_cnt_q + 8'd1;
                        if (bus.period != '0) target_d = target_q + bus.period;
                        else                  state_d  = S_FIRED;
`else
                        state_d = S_FIRED;
`endif
                    end
                end
                S_FIRED: begin
                    if (bus.irq_ack) begin
                        irq_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.timer_enable = bus.en_req | (state_q != S_IDLE);
    assign bus.timer_sample = (state_q == S_SAMPLE) || (state_q == S_ARMED);
    assign bus.irq          = irq_q;
    assign bus.state        = state_q;
`ifdef TIMER_ALARM_PERIODIC_EN
    assign bus.miss_cnt     = miss_cnt_q;
`endif
endmodule

// File: tb/tb_iob_timer_alarm.sv
// Self-checking bench for iob_timer_alarm with a behavioural timer_core (1-cycle sample lag).
// Periodic-mode sequences are compiled only when TIMER_ALARM_PERIODIC_EN is defined.
module tb_iob_timer_alarm;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 2 * DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iob_timer_alarm_if #(.DATA_W(DATA_W)) bus ();
    iob_timer_alarm #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // timer_core model: live count plus a sampled copy updated while timer_sample is high
    logic [CNT_W-1:0] cnt;
    logic             load_en;
    logic [CNT_W-1:0] load_val;
    always @(posedge clk) begin
        if (bus.timer_sample) bus.timer_value <= cnt;
        if (load_en)               cnt <= load_val;
        else if (bus.timer_enable) cnt <= cnt + 1'b1;
    end

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    typedef struct {
        string            name;
        logic [CNT_W-1:0] c0;       // live count just before the arm edge
        logic [CNT_W-1:0] dly;
        int               edges;    // edges after the arm edge until irq is visible
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_arm(input logic [CNT_W-1:0] d);
        bus.delay = d;
        bus.arm   = 1'b1;
        @(negedge clk);
        bus.arm   = 1'b0;
    endtask

    task automatic wait_irq(input int budget, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (n < budget && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = bus.irq;
        end
    endtask

    task automatic load_count(input logic [CNT_W-1:0] v);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit seen;
        int exp_edges;
        load_count(v.c0);
        exp_q.push_back(v.edges);
        pulse_arm(v.dly);
        wait_irq(v.edges + 20, n, seen);
        exp_edges = exp_q.pop_front();
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: no irq within %0d edges, expected at %0d", v.name, n, exp_edges);
        end else begin
            check({v.name, "_latency"}, 64'(n), 64'(exp_edges));
            check({v.name, "_state_fired"}, 64'(bus.state), 64'd4);
        end
        bus.irq_ack = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0;
        check({v.name, "_ack_irq"}, 64'(bus.irq), 64'd0);
        check({v.name, "_ack_state"}, 64'(bus.state), 64'd0);
        $display("vec %-10s c0=%0d delay=%0d irq after %0d edges (expected %0d)", v.name, v.c0, v.dly, n, exp_edges);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        vecs[0] = '{"d0",      64'd500,                        64'd0,          3};
        vecs[1] = '{"d1",      64'd500,                        64'd1,          4};
        vecs[2] = '{"d2",      64'd500,                        64'd2,          4};
        vecs[3] = '{"cnt100",  64'd99,                         64'd10,         12};
        vecs[4] = '{"d37",     64'd7000,                       64'd37,         39};
        vecs[5] = '{"wrap",    64'hFFFF_FFFF_FFFF_FFFA,        64'd10,         12};
        vecs[6] = '{"huge",    64'd1234,                       64'h8000_0000_0000_0000, 3};

        rst         = 1'b1;
        load_en     = 1'b0;
        load_val    = '0;
        bus.en_req  = 1'b0;
        bus.arm     = 1'b0;
        bus.disarm  = 1'b0;
        bus.delay   = '0;
        bus.irq_ack = 1'b0;
`ifdef TIMER_ALARM_PERIODIC_EN
        bus.period  = '0;
`endif
        #1;
        check("rst_state", 64'(bus.state), 64'd0);
        check("rst_irq", 64'(bus.irq), 64'd0);
        check("rst_sample", 64'(bus.timer_sample), 64'd0);
        check("rst_enable_lo", 64'(bus.timer_enable), 64'd0);
        bus.en_req = 1'b1;
        #1;
        check("rst_enable_hi", 64'(bus.timer_enable), 64'd1);
        @(negedge clk);
        load_count(64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // ack with irq low is ignored; arm+disarm together resolves to disarm
        pulse_arm(64'd1000);
        repeat (4) @(negedge clk);
        check("armed_state", 64'(bus.state), 64'd3);
        bus.irq_ack = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0;
        check("idle_ack_state", 64'(bus.state), 64'd3);
        check("idle_ack_irq", 64'(bus.irq), 64'd0);
        bus.arm = 1'b1;
        bus.disarm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        bus.disarm = 1'b0;
        check("arm_disarm_state", 64'(bus.state), 64'd0);
        check("arm_disarm_irq", 64'(bus.irq), 64'd0);
        $display("seq ack-ignored / arm+disarm done");

        // re-arm out of FIRED restarts and drops irq, then async reset while ARMED
        pulse_arm(64'd0);
        wait_irq(10, n, seen);
        check("fired_irq", 64'(bus.irq), 64'd1);
        pulse_arm(64'd1000);
        check("rearm_state", 64'(bus.state), 64'd1);
        check("rearm_irq", 64'(bus.irq), 64'd0);
        repeat (2) @(negedge clk);
        check("rearm_armed", 64'(bus.state), 64'd3);
        rst = 1'b1;
        #1;
        check("rst_mid_state", 64'(bus.state), 64'd0);
        check("rst_mid_sample", 64'(bus.timer_sample), 64'd0);
        check("rst_mid_enable", 64'(bus.timer_enable), 64'd1);
        bus.en_req = 1'b0;
        #1;
        check("rst_mid_enable_lo", 64'(bus.timer_enable), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.en_req = 1'b1;
        @(negedge clk);
        $display("seq restart / reset-mid-armed done");

        // pending irq is lost on reset; disarm clears a pending irq
        pulse_arm(64'd0);
        wait_irq(10, n, seen);
        check("pend_irq", 64'(bus.irq), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_pend_irq", 64'(bus.irq), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_arm(64'd0);
        wait_irq(10, n, seen);
        check("d0_again_edges", 64'(n), 64'd3);
        bus.disarm = 1'b1;
        @(negedge clk);
        bus.disarm = 1'b0;
        check("disarm_irq", 64'(bus.irq), 64'd0);
        check("disarm_state", 64'(bus.state), 64'd0);
        $display("seq reset-pending / disarm done");

`ifdef TIMER_ALARM_PERIODIC_EN
        begin
            int total;
            int exp_edge;
            total = 0;
            bus.period = 64'd50;
            load_count(64'd1000);
            pulse_arm(64'd20);
            for (int k = 0; k < 3; k++) begin
                exp_q.push_back(22 + 50 * k);
                seen = 1'b0;
                while (total < 400 && !seen) begin
                    @(posedge clk);
                    total++;
                    @(negedge clk);
                    seen = bus.irq;
                end
                exp_edge = exp_q.pop_front();
                check("periodic_edge", 64'(total), 64'(exp_edge));
                check("periodic_state", 64'(bus.state), 64'd3);
                bus.irq_ack = 1'b1;
                @(posedge clk);
                total++;
                @(negedge clk);
                bus.irq_ack = 1'b0;
                check("periodic_ack_irq", 64'(bus.irq), 64'd0);
                $display("periodic irq %0d at edge %0d (expected %0d)", k, total - 1, exp_edge);
            end
            check("periodic_miss_zero", 64'(bus.miss_cnt), 64'd0);
            bus.disarm = 1'b1;
            @(negedge clk);
            bus.disarm = 1'b0;

            bus.period = 64'd4;
            pulse_arm(64'd4);
            repeat (1210) @(negedge clk);
            check("sat_irq", 64'(bus.irq), 64'd1);
            check("sat_miss", 64'(bus.miss_cnt), 64'd255);
            check("sat_state", 64'(bus.state), 64'd3);
            pulse_arm(64'd1000);
            check("sat_arm_miss", 64'(bus.miss_cnt), 64'd0);
            check("sat_arm_irq", 64'(bus.irq), 64'd0);
            bus.period = '0;
            bus.disarm = 1'b1;
            @(negedge clk);
            bus.disarm = 1'b0;
            $display("seq periodic saturation done");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
